// File: rtl/wb_lanes_stage_t.sv
// Writeback stage: registers a bundle of up to LANES results and drains the
// pending lanes onto WPORTS register-file write ports, lowest lane first.
module wb_lanes_stage_t #(
    parameter int LANES  = 2,
    parameter int WPORTS = 1,
    parameter int XLEN   = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*XLEN-1:0]   in_alu,
    input  logic [LANES*XLEN-1:0]   in_memdat,
    input  logic [LANES*XLEN-1:0]   in_pc,
    input  logic [LANES*5-1:0]      in_rd,
    input  logic [LANES*2-1:0]      in_rfwt_sel,
    input  logic [LANES-1:0]        in_wten,
    output logic [WPORTS*XLEN-1:0]  rf_xpr_wrt_D,
    output logic [WPORTS*5-1:0]     rf_xpr_wrt_WA,
    output logic [WPORTS-1:0]       rf_xpr_wrt_WE,
    output logic                    busy,
    output logic [31:0]             retired_cnt
);

    // Handshake: a bundle transfers at a rising edge where in_valid && in_ready;
    // in_valid must hold the bundle steady until that edge.

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              state_q;
    logic [LANES-1:0]    pend_q;
    logic [LANES-1:0]    pend_d;
    logic [31:0]         retired_q;
    logic [XLEN-1:0]     data_q [LANES];
    logic [4:0]          rd_q   [LANES];

    logic [XLEN-1:0]     res_d  [LANES];
    logic [LANES-1:0]    new_mask;
    logic [2:0]          acc_cnt;
    logic [2:0]          rank   [LANES];
    logic [2:0]          pend_cnt;
    logic [LANES-1:0]    issue_mask;
    logic [WPORTS-1:0]   port_v;
    logic [XLEN-1:0]     port_d  [WPORTS];
    logic [4:0]          port_wa [WPORTS];
    logic [WPORTS-1:0]   port_we;
    logic                accept;

    // Result selection happens at acceptance so only the final value is stored.
    always_comb begin
        new_mask = '0;
        acc_cnt  = '0;
        for (int i = 0; i < LANES; i++) begin
            res_d[i] = '0;
            case (in_rfwt_sel[i*2 +: 2])
                2'd0:    res_d[i] = in_alu[i*XLEN +: XLEN];
                2'd1:    res_d[i] = in_pc[i*XLEN +: XLEN] + XLEN'(4);
                2'd2:    res_d[i] = in_memdat[i*XLEN +: XLEN];
                default: res_d[i] = '0;
            endcase
            new_mask[i] = in_lane_valid[i] & in_wten[i] & (in_rd[i*5 +: 5] != 5'd0);
            acc_cnt     = acc_cnt + {2'b00, in_lane_valid[i]};
        end
    end

    // rank[i] = number of pending lanes below lane i, i.e. the port lane i uses.
    always_comb begin
        rank[0] = '0;
        for (int i = 1; i < LANES; i++) begin
            rank[i] = rank[i-1] + {2'b00, pend_q[i-1]};
        end
        pend_cnt = rank[LANES-1] + {2'b00, pend_q[LANES-1]};
        for (int i = 0; i < LANES; i++) begin
            issue_mask[i] = pend_q[i] && (rank[i] < 3'(WPORTS));
        end
    end

    always_comb begin
        port_v = '0;
        for (int p = 0; p < WPORTS; p++) begin
            port_d[p]  = '0;
            port_wa[p] = '0;
            for (int i = 0; i < LANES; i++) begin
                if (pend_q[i] && (rank[i] == 3'(p))) begin
                    port_v[p]  = 1'b1;
                    port_d[p]  = data_q[i];
                    port_wa[p] = rd_q[i];
                end
            end
        end
    end

    // Higher ports always carry higher lanes, so a later port with the same rd wins.
    always_comb begin
        port_we       = '0;
        rf_xpr_wrt_D  = '0;
        rf_xpr_wrt_WA = '0;
        for (int p = 0; p < WPORTS; p++) begin
            port_we[p] = port_v[p] & ~flush;
            for (int q = p + 1; q < WPORTS; q++) begin
                if (port_v[q] && (port_wa[q] == port_wa[p])) begin
                    port_we[p] = 1'b0;
                end
            end
            if (port_we[p]) begin
                rf_xpr_wrt_D[p*XLEN +: XLEN] = port_d[p];
                rf_xpr_wrt_WA[p*5 +: 5]      = port_wa[p];
            end
        end
        rf_xpr_wrt_WE = port_we;
    end

    assign in_ready = !RST && !flush && (pend_cnt <= 3'(WPORTS));
    assign accept   = in_valid && in_ready;

    // Acceptance only happens when every remaining lane issues this cycle.
    always_comb begin
        if (flush) begin
            pend_d = '0;
        end else if (accept) begin
            pend_d = new_mask;
        end else begin
            pend_d = pend_q & ~issue_mask;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            retired_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            state_q <= (pend_d != '0) ? ST_DRAIN : ST_IDLE;
            if (accept) begin
                retired_q <= retired_q + 32'(acc_cnt);
                for (int i = 0; i < LANES; i++) begin
                    data_q[i] <= res_d[i];
                    rd_q[i]   <= in_rd[i*5 +: 5];
                end
            end
        end
    end

    assign busy        = (state_q == ST_DRAIN);
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_wb_lanes_stage_t.sv
// Directed bench for wb_lanes_stage_t: one instance with a single write port
// and one with two write ports, sharing clock and reset.
module tb_wb_lanes_stage_t;

    logic        CLK;
    logic        RST;
    int          n_tests;
    int          n_fail;
    logic [31:0] exp_ret;

    // Instance A: LANES=2, WPORTS=1
    logic        a_flush, a_valid, a_ready, a_we, a_busy;
    logic [1:0]  a_lv, a_wten;
    logic [63:0] a_alu, a_mem, a_pc;
    logic [9:0]  a_rd;
    logic [3:0]  a_sel;
    logic [31:0] a_d, a_ret;
    logic [4:0]  a_wa;

    // Instance B: LANES=2, WPORTS=2
    logic        b_flush, b_valid, b_ready, b_busy;
    logic [1:0]  b_lv, b_wten, b_we;
    logic [63:0] b_alu, b_mem, b_pc;
    logic [9:0]  b_rd;
    logic [3:0]  b_sel;
    logic [63:0] b_d;
    logic [9:0]  b_wa;
    logic [31:0] b_ret;

    wb_lanes_stage_t #(.LANES(2), .WPORTS(1), .XLEN(32)) u_a (
        .CLK(CLK), .RST(RST), .flush(a_flush), .in_valid(a_valid), .in_ready(a_ready),
        .in_lane_valid(a_lv), .in_alu(a_alu), .in_memdat(a_mem), .in_pc(a_pc),
        .in_rd(a_rd), .in_rfwt_sel(a_sel), .in_wten(a_wten),
        .rf_xpr_wrt_D(a_d), .rf_xpr_wrt_WA(a_wa), .rf_xpr_wrt_WE(a_we),
        .busy(a_busy), .retired_cnt(a_ret)
    );

    wb_lanes_stage_t #(.LANES(2), .WPORTS(2), .XLEN(32)) u_b (
        .CLK(CLK), .RST(RST), .flush(b_flush), .in_valid(b_valid), .in_ready(b_ready),
        .in_lane_valid(b_lv), .in_alu(b_alu), .in_memdat(b_mem), .in_pc(b_pc),
        .in_rd(b_rd), .in_rfwt_sel(b_sel), .in_wten(b_wten),
        .rf_xpr_wrt_D(b_d), .rf_xpr_wrt_WA(b_wa), .rf_xpr_wrt_WE(b_we),
        .busy(b_busy), .retired_cnt(b_ret)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic clear_a();
        a_flush = 0; a_valid = 0; a_lv = '0; a_wten = '0;
        a_alu = '0; a_mem = '0; a_pc = '0; a_rd = '0; a_sel = '0;
    endtask

    task automatic set_lane_a(input int l, input logic [1:0] sel, input logic [31:0] alu,
                              input logic [31:0] mem, input logic [31:0] pc, input logic [4:0] rd);
        a_lv[l] = 1'b1;
        a_wten[l] = 1'b1;
        a_sel[l*2 +: 2] = sel;
        a_alu[l*32 +: 32] = alu;
        a_mem[l*32 +: 32] = mem;
        a_pc[l*32 +: 32] = pc;
        a_rd[l*5 +: 5] = rd;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_a();
        b_flush = 0; b_valid = 0; b_lv = '0; b_wten = '0;
        b_alu = '0; b_mem = '0; b_pc = '0; b_rd = '0; b_sel = '0;
        @(negedge CLK); #1;
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a: got %0b want 0", a_ready); end
        n_tests++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_b: got %0b want 0", b_ready); end
        n_tests++; if ({a_we, a_wa, a_d} !== '0) begin n_fail++; $display("FAIL reset_port_a: we=%0b wa=%0d d=%h want 0", a_we, a_wa, a_d); end
        n_tests++; if (a_ret !== 32'd0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_busy: ret=%h busy=%0b want 0/0", a_ret, a_busy); end
        RST = 1'b0;
        #1;
        n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: a=%0b b=%0b want 1/1", a_ready, b_ready); end
        exp_ret = 32'd0;
    endtask

    task automatic test_basic();
        @(negedge CLK);
        clear_a();
        set_lane_a(0, 2'd0, 32'h11, 32'h0, 32'h0, 5'd5);
        set_lane_a(1, 2'd2, 32'h0, 32'h22, 32'h0, 5'd6);
        a_valid = 1;
        @(negedge CLK);
        a_valid = 0;
        exp_ret = exp_ret + 2;
        #1;
        n_tests++; if (a_we !== 1'b1 || a_wa !== 5'd5 || a_d !== 32'h11) begin n_fail++; $display("FAIL basic_c1: we=%0b wa=%0d d=%h want 1/5/11", a_we, a_wa, a_d); end
        n_tests++; if (a_ready !== 1'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL basic_c1_ready: ready=%0b busy=%0b want 0/1", a_ready, a_busy); end
        n_tests++; if (a_ret !== exp_ret) begin n_fail++; $display("FAIL basic_ret: got %h want %h", a_ret, exp_ret); end
        @(negedge CLK); #1;
        n_tests++; if (a_we !== 1'b1 || a_wa !== 5'd6 || a_d !== 32'h22) begin n_fail++; $display("FAIL basic_c2: we=%0b wa=%0d d=%h want 1/6/22", a_we, a_wa, a_d); end
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL basic_c2_ready: got %0b want 1", a_ready); end
        @(negedge CLK); #1;
        n_tests++; if (a_we !== 1'b0 || a_busy !== 1'b0 || a_d !== 32'h0) begin n_fail++; $display("FAIL basic_done: we=%0b busy=%0b d=%h want 0/0/0", a_we, a_busy, a_d); end
    endtask

    task automatic test_collision();
        @(negedge CLK);
        b_lv = 2'b11; b_wten = 2'b11;
        b_sel = {2'd1, 2'd0};
        b_alu = {32'h0, 32'hA};
        b_pc  = {32'h100, 32'h0};
        b_rd  = {5'd7, 5'd7};
        b_valid = 1;
        #1;
        n_tests++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready: got %0b want 1", b_ready); end
        @(negedge CLK);
        b_valid = 0;
        #1;
        n_tests++; if (b_we !== 2'b10) begin n_fail++; $display("FAIL coll_we: got %b want 10", b_we); end
        n_tests++; if (b_wa !== {5'd7, 5'd0} || b_d !== {32'h104, 32'h0}) begin n_fail++; $display("FAIL coll_port: wa=%h d=%h want port1 7/104, port0 0/0", b_wa, b_d); end
        n_tests++; if (b_ret !== 32'd2) begin n_fail++; $display("FAIL coll_ret: got %h want 2", b_ret); end
        @(negedge CLK); #1;
        n_tests++; if (b_we !== 2'b00 || b_busy !== 1'b0) begin n_fail++; $display("FAIL coll_done: we=%b busy=%0b want 00/0", b_we, b_busy); end
    endtask

    task automatic test_x0();
        @(negedge CLK);
        clear_a();
        set_lane_a(0, 2'd0, 32'h33, 32'h0, 32'h0, 5'd0);
        set_lane_a(1, 2'd0, 32'h44, 32'h0, 32'h0, 5'd3);
        a_valid = 1;
        @(negedge CLK);
        a_valid = 0;
        exp_ret = exp_ret + 2;
        #1;
        n_tests++; if (a_we !== 1'b1 || a_wa !== 5'd3 || a_d !== 32'h44) begin n_fail++; $display("FAIL x0_write: we=%0b wa=%0d d=%h want 1/3/44", a_we, a_wa, a_d); end
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0b want 1", a_ready); end
        @(negedge CLK); #1;
        n_tests++; if (a_we !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL x0_done: we=%0b busy=%0b want 0/0", a_we, a_busy); end
        n_tests++; if (a_ret !== exp_ret) begin n_fail++; $display("FAIL x0_ret: got %h want %h", a_ret, exp_ret); end
    endtask

    task automatic test_flush();
        @(negedge CLK);
        clear_a();
        set_lane_a(0, 2'd0, 32'h55, 32'h0, 32'h0, 5'd10);
        set_lane_a(1, 2'd0, 32'h66, 32'h0, 32'h0, 5'd11);
        a_valid = 1;
        @(negedge CLK);
        a_valid = 0;
        a_flush = 1;
        exp_ret = exp_ret + 2;
        #1;
        n_tests++; if (a_we !== 1'b0 || a_wa !== 5'd0 || a_d !== 32'h0) begin n_fail++; $display("FAIL flush_we: we=%0b wa=%0d d=%h want 0/0/0", a_we, a_wa, a_d); end
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b want 0", a_ready); end
        @(negedge CLK);
        a_flush = 0;
        #1;
        n_tests++; if (a_we !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL flush_after: we=%0b busy=%0b want 0/0", a_we, a_busy); end
        n_tests++; if (a_ret !== exp_ret) begin n_fail++; $display("FAIL flush_ret: got %h want %h", a_ret, exp_ret); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  want_wa [4];
        logic [31:0] want_d  [4];
        want_wa[0] = 5'd1; want_wa[1] = 5'd2; want_wa[2] = 5'd3; want_wa[3] = 5'd4;
        want_d[0] = 32'h1; want_d[1] = 32'h2; want_d[2] = 32'h3; want_d[3] = 32'h4;
        @(negedge CLK);
        clear_a();
        set_lane_a(0, 2'd0, 32'h1, 32'h0, 32'h0, 5'd1);
        set_lane_a(1, 2'd0, 32'h2, 32'h0, 32'h0, 5'd2);
        a_valid = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                set_lane_a(0, 2'd0, 32'h3, 32'h0, 32'h0, 5'd3);
                set_lane_a(1, 2'd0, 32'h4, 32'h0, 32'h0, 5'd4);
            end
            if (c == 2) a_valid = 0;
            #1;
            n_tests++;
            if (a_we !== 1'b1 || a_wa !== want_wa[c] || a_d !== want_d[c]) begin
                n_fail++;
                $display("FAIL b2b_c%0d: we=%0b wa=%0d d=%h want 1/%0d/%h", c, a_we, a_wa, a_d, want_wa[c], want_d[c]);
            end
        end
        exp_ret = exp_ret + 4;
        @(negedge CLK); #1;
        n_tests++; if (a_we !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done: we=%0b busy=%0b want 0/0", a_we, a_busy); end
        n_tests++; if (a_ret !== exp_ret) begin n_fail++; $display("FAIL b2b_ret: got %h want %h", a_ret, exp_ret); end
    endtask

    task automatic test_wrap_and_reset();
        @(negedge CLK);
        force u_a.retired_q = 32'hFFFF_FFFD;
        #1;
        release u_a.retired_q;
        clear_a();
        set_lane_a(0, 2'd0, 32'h77, 32'h0, 32'h0, 5'd8);
        set_lane_a(1, 2'd0, 32'h88, 32'h0, 32'h0, 5'd9);
        a_valid = 1;
        @(negedge CLK);
        a_valid = 0;
        #1;
        n_tests++; if (a_ret !== 32'hFFFF_FFFF || a_we !== 1'b1 || a_wa !== 5'd8) begin n_fail++; $display("FAIL pre_rst: ret=%h we=%0b wa=%0d want ffffffff/1/8", a_ret, a_we, a_wa); end
        #2;
        RST = 1'b1;
        #1;
        n_tests++; if (a_we !== 1'b0 || a_wa !== 5'd0 || a_d !== 32'h0) begin n_fail++; $display("FAIL async_rst_port: we=%0b wa=%0d d=%h want 0/0/0", a_we, a_wa, a_d); end
        n_tests++; if (a_ret !== 32'd0 || a_busy !== 1'b0 || a_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_state: ret=%h busy=%0b ready=%0b want 0/0/0", a_ret, a_busy, a_ready); end
        @(negedge CLK);
        RST = 1'b0;
        force u_a.retired_q = 32'hFFFF_FFFF;
        #1;
        release u_a.retired_q;
        a_valid = 1;
        @(negedge CLK);
        a_valid = 0;
        #1;
        n_tests++; if (a_ret !== 32'h1) begin n_fail++; $display("FAIL wrap_ret: got %h want 00000001", a_ret); end
        n_tests++; if (a_we !== 1'b1 || a_wa !== 5'd8 || a_d !== 32'h77) begin n_fail++; $display("FAIL wrap_write: we=%0b wa=%0d d=%h want 1/8/77", a_we, a_wa, a_d); end
        @(negedge CLK); @(negedge CLK);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_ret = '0;
        test_reset();
        test_basic();
        test_collision();
        test_x0();
        test_flush();
        test_back_to_back();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_lanes_stage_t.md
WB_LANES_STAGE_T -- requirements
Module: wb_lanes_stage_t

Interface
REQ-001 Parameter LANES, default 2: number of writeback lanes per bundle (1..4).
REQ-002 Parameter WPORTS, default 1: number of register-file write ports (1..LANES).
REQ-003 Parameter XLEN, default 32: data and PC width.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  discards the pending bundle.
REQ-007 in_valid  in  1  bundle offered.
REQ-008 in_ready  out  1  bundle accepted at an edge where in_valid && in_ready.
REQ-009 in_lane_valid  in  LANES  per-lane instruction valid.
REQ-010 in_alu, in_memdat, in_pc  in  LANES*XLEN each  per-lane ALU result, load data and PC; lane i occupies bits [i*XLEN +: XLEN].
REQ-011 in_rd  in  LANES*5  per-lane destination register.
REQ-012 in_rfwt_sel  in  LANES*2  per-lane result select.
REQ-013 in_wten  in  LANES  per-lane write enable.
REQ-014 rf_xpr_wrt_D  out  WPORTS*XLEN  write data per port.
REQ-015 rf_xpr_wrt_WA  out  WPORTS*5  write address per port.
REQ-016 rf_xpr_wrt_WE  out  WPORTS  write enable per port.
REQ-017 busy  out  1  pending writes exist.
REQ-018 retired_cnt  out  32  count of retired lane instructions.

Function
REQ-019 Per-lane result select: 0 -> alu; 1 -> pc+4 (mod 2^XLEN); 2 -> memdat; 3 -> zero.
REQ-020 On acceptance, all lane fields are registered and pending mask = in_lane_valid & in_wten & (in_rd != 0).
REQ-021 Writes to x0 are never issued.
REQ-022 FSM states: IDLE (pending mask zero) and DRAIN (pending mask non-zero).
REQ-023 Transitions: IDLE -> DRAIN on accepting a bundle with a non-zero mask; DRAIN -> IDLE when the last pending lanes issue and no new bundle is accepted; DRAIN -> DRAIN on back-to-back acceptance.
REQ-024 Each cycle in DRAIN, the up-to-WPORTS lowest-indexed pending lanes issue on ports 0,1,... in ascending lane order, and their mask bits clear at the next edge.
REQ-025 Writeback latency: the first write of a bundle appears in the cycle after acceptance; a bundle with k pending lanes completes in ceil(k/WPORTS) cycles.
REQ-026 in_ready = !flush && (pending count <= WPORTS), which permits acceptance in the final drain cycle with no bubble.
REQ-027 Same-cycle collision: if two ports carry the same rd, the lower lane's WE is suppressed so that only the higher lane writes; across cycles the ascending order already gives higher lanes the final value.
REQ-028 Ports with WE=0 drive D=0 and WA=0.
REQ-029 retired_cnt increases by popcount(in_lane_valid) at each acceptance and wraps mod 2^32.
REQ-030 flush: all WE forced to 0 in the flush cycle, pending mask cleared at the edge, no acceptance that cycle, retired_cnt unchanged.
REQ-031 busy = (state == DRAIN).

Reset
REQ-032 RST asserted, including mid-drain, immediately clears the pending mask and sets state to IDLE, retired_cnt to 0, and all WE/WA/D outputs to 0.
REQ-033 While RST is high, in_ready = 0; in_ready = 1 from the first cycle after RST deasserts (flush low).

Verification
REQ-034 LANES=2, WPORTS=1, one bundle {lane0: sel0, alu=0x11, rd=5; lane1: sel2, memdat=0x22, rd=6} -> cycle+1 port0 WA=5 D=0x11; cycle+2 WA=6 D=0x22; in_ready=0 at cycle+1, 1 at cycle+2; retired_cnt=2.
REQ-035 WPORTS=2, both lanes rd=7 (lane0 alu 0xA, lane1 sel1 pc=0x100) -> only port1 WE: WA=7, D=0x104.
REQ-036 Lane with rd=0 and wten=1 alongside lane1 rd=3 -> a single write to x3 with no x0 write; drain takes 1 cycle.
REQ-037 flush in the first drain cycle of a 2-write bundle -> no WE in that cycle or after; busy=0 next cycle; retired_cnt keeps its accepted value.
REQ-038 RST pulse mid-drain with retired_cnt=0xFFFFFFFF -> outputs zero asynchronously and retired_cnt=0; separately, without reset, accepting a 2-lane bundle at 0xFFFFFFFF wraps retired_cnt to 0x1.
REQ-039 Back-to-back bundles, WPORTS=1, in_valid held high -> port0 WE continuous with no bubble cycles; issue order b0L0, b0L1, b1L0, b1L1.
